// File: rtl/receiver.sv
// rtl/receiver.sv - UART 8N1 receive stage with mid-bit sampling and valid/rd handshake
module receiver #(
    parameter int WAIT_DIV = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       rd,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int        HALF_DIV  = WAIT_DIV / 2;
    localparam logic [9:0] WAIT_LAST = 10'(WAIT_DIV - 1);
    localparam logic [9:0] HALF_LAST = 10'(HALF_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t     state_q, state_d;
    logic       rx_meta_q, rx_s_q;
    logic [9:0] wait_q, wait_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       fe_q, fe_d;
    logic       ov_q, ov_d;

    // Synchroniser resets to 1 so a reset never looks like a start edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            fe_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            fe_q    <= fe_d;
            ov_q    <= ov_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;
        fe_d    = 1'b0;
        ov_d    = 1'b0;

        if (rd && valid_q) begin
            valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    state_d = S_START;
                    wait_d  = '0;
                end
            end
            S_START: begin
                if (wait_q == HALF_LAST) begin
                    wait_d  = '0;
                    bit_d   = '0;
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end else begin
                    wait_d = wait_q + 10'd1;
                end
            end
            S_DATA: begin
                if (wait_q == WAIT_LAST) begin
                    shift_d = {rx_s_q, shift_q[7:1]};
                    wait_d  = '0;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    wait_d = wait_q + 10'd1;
                end
            end
            S_STOP: begin
                if (wait_q == WAIT_LAST) begin
                    wait_d = '0;
                    if (rx_s_q) begin
                        // Delivery takes priority over a same-cycle rd clear
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        ov_d    = valid_q && !rd;
                        state_d = S_IDLE;
                    end else begin
                        fe_d    = 1'b1;
                        state_d = S_BREAK;
                    end
                end else begin
                    wait_d = wait_q + 10'd1;
                end
            end
            S_BREAK: begin
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign data_out  = data_q;
    assign valid     = valid_q;
    assign frame_err = fe_q;
    assign overrun   = ov_q;
    assign busy      = (state_q != S_IDLE);

endmodule
